fetch_seq: RTL and testbench

- Fetch-stage sequencer between the PC register logic and a variable-latency instruction memory with a req/ack handshake.
- Issues one fetch at a time, buffers the returned word for the D stage, and honours the D-stage stall.
- Applies branch/jump redirects after the delay-slot fetch.
- Halts with a sticky fault on an out-of-range or misaligned PC.

---
 rtl/fetch_seq_pkg.sv | 22 ++
 rtl/fetch_seq_if.sv | 26 ++
 rtl/fetch_redirect_latch.sv | 44 ++++
 rtl/fetch_seq.sv | 132 +++++++++++++
 tb/tb_fetch_seq.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch-stage sequencer: state encoding,
// instruction-space bounds and the legal-PC test used by the PC logic.
package fetch_seq_pkg;

  localparam logic [31:0] PC_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] PC_LIMIT_DEF = 32'h0000_6FFF;
  localparam int          IMEM_AW_DEF  = 12;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  // Word-aligned and inside [base, limit]; pc+4 past the limit fails here too.
  function automatic logic pc_legal(input logic [31:0] pc,
                                    input logic [31:0] base,
                                    input logic [31:0] limit);
    return (pc >= base) && (pc <= limit) && (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer
// (master) and the instruction memory (slave).
interface fetch_seq_if #(
  parameter int AW = 12
);

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_redirect_latch.sv
// Holds a redirect seen while a fetch is in flight and selects the PC that
// follows the fetch currently being acknowledged.
module fetch_redirect_latch
  import fetch_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_fetch,
  input  logic        ack_taken,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] pc,
  output logic [31:0] npc
);

  logic        pend_valid_r;
  logic [31:0] pend_pc_r;

  // Capture the newest redirect during an unacknowledged fetch; drop it once used.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid_r <= 1'b0;
      pend_pc_r    <= 32'h0000_0000;
    end else if (ack_taken) begin
      pend_valid_r <= 1'b0;
    end else if (in_fetch && redirect_valid) begin
      pend_valid_r <= 1'b1;
      pend_pc_r    <= redirect_pc;
    end
  end

  // A redirect arriving with the ack outranks an older pending one.
  always_comb begin
    npc = pc + 32'd4;
    if (redirect_valid) begin
      npc = redirect_pc;
    end else if (pend_valid_r) begin
      npc = pend_pc_r;
    end else begin
      npc = pc + 32'd4;
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Fetch-stage sequencer: one outstanding imem fetch, a single-entry
// instruction buffer for D, delayed-branch redirects and a sticky PC fault.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] PC_BASE  = PC_BASE_DEF,
  parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEF,
  parameter int          IMEM_AW  = IMEM_AW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  fetch_seq_if.master        imem,
  output logic               instr_valid,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  output logic               fault
);

  fetch_state_t       state_r;
  logic [31:0]        pc_r;
  logic [IMEM_AW-1:0] addr_r;
  logic               req_r;
  logic               instr_valid_r;
  logic [31:0]        instr_r;
  logic [31:0]        instr_pc_r;
  logic               fault_r;

  logic               in_fetch_s;
  logic               ack_taken_s;
  logic [31:0]        npc_s;
  logic               npc_legal_s;
  logic               redir_legal_s;
  logic [IMEM_AW-1:0] npc_idx_s;
  logic [IMEM_AW-1:0] redir_idx_s;

  // req_r is low for the first cycle out of reset, so no ack can be taken then.
  assign in_fetch_s    = (state_r == ST_FETCH);
  assign ack_taken_s   = in_fetch_s && req_r && imem.imem_ack;
  assign npc_legal_s   = pc_legal(npc_s, PC_BASE, PC_LIMIT);
  assign redir_legal_s = pc_legal(redirect_pc, PC_BASE, PC_LIMIT);
  assign npc_idx_s     = IMEM_AW'((npc_s - PC_BASE) >> 2);
  assign redir_idx_s   = IMEM_AW'((redirect_pc - PC_BASE) >> 2);

  fetch_redirect_latch u_redirect (
    .clk            (clk),
    .reset          (reset),
    .in_fetch       (in_fetch_s),
    .ack_taken      (ack_taken_s),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc_r),
    .npc            (npc_s)
  );

  // Sequencer FSM with the PC, imem request and instruction buffer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_FETCH;
      pc_r          <= PC_BASE;
      addr_r        <= '0;
      req_r         <= 1'b0;
      instr_valid_r <= 1'b0;
      instr_r       <= 32'h0000_0000;
      instr_pc_r    <= PC_BASE;
      fault_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (ack_taken_s) begin
            instr_r       <= imem.imem_rdata;
            instr_pc_r    <= pc_r;
            instr_valid_r <= 1'b1;
            req_r         <= 1'b0;
            if (npc_legal_s) begin
              pc_r    <= npc_s;
              addr_r  <= npc_idx_s;
              state_r <= ST_HOLD;
            end else begin
              fault_r <= 1'b1;
              state_r <= ST_HALT;
            end
          end else begin
            req_r <= 1'b1;
          end
        end
        ST_HOLD: begin
          // An illegal target faults now but the buffered word is still handed over.
          if (redirect_valid && !fault_r) begin
            if (redir_legal_s) begin
              pc_r   <= redirect_pc;
              addr_r <= redir_idx_s;
            end else begin
              fault_r <= 1'b1;
            end
          end
          if (!stall) begin
            instr_valid_r <= 1'b0;
            if (fault_r || (redirect_valid && !redir_legal_s)) begin
              state_r <= ST_HALT;
              req_r   <= 1'b0;
            end else begin
              state_r <= ST_FETCH;
              req_r   <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          req_r <= 1'b0;
          if (!stall) begin
            instr_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_HALT;
          req_r   <= 1'b0;
          fault_r <= 1'b1;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = addr_r;
  assign instr_valid    = instr_valid_r;
  assign instr          = instr_r;
  assign instr_pc       = instr_pc_r;
  assign fault          = fault_r;

endmodule

// File: tb/tb_fetch_seq.sv
// Cycle-table bench for fetch_seq: per-cycle inputs and expected outputs,
// plus a delivery scoreboard fed from the table's acknowledged addresses.
module tb_fetch_seq;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fault;

  fetch_seq_if #(.AW(12)) bus ();

  fetch_seq dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst_before;
    bit          e_req;
    logic [11:0] e_addr;
    bit          e_valid;
    logic [31:0] e_ipc;
    bit          e_fault;
    bit          stall;
    bit          rv;
    logic [31:0] rpc;
    bit          ack;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  bit          prev_valid = 1'b0;
  int          part1_rows;

  function automatic logic [31:0] mem_word(input logic [11:0] idx);
    return 32'hC0DE_0000 ^ {4'h0, idx, 4'h0, idx};
  endfunction

  function automatic vec_t mk(input bit rb, input bit er, input logic [11:0] ea,
                              input bit ev, input logic [31:0] eipc, input bit ef,
                              input bit st, input bit rv, input logic [31:0] rpc,
                              input bit ack);
    vec_t v;
    v.rst_before = rb; v.e_req = er; v.e_addr = ea; v.e_valid = ev;
    v.e_ipc = eipc; v.e_fault = ef; v.stall = st; v.rv = rv; v.rpc = rpc; v.ack = ack;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0000_0000;
  endtask

  // Called at a falling edge: assert reset between edges, check, release at the next falling edge.
  task automatic reset_pulse(input string tag);
    #2;
    reset = 1'b0;
    drive_idle();
    #1;
    chk({tag, "_req"},   {31'h0, bus.imem_req}, 32'h0);
    chk({tag, "_addr"},  {20'h0, bus.imem_addr}, 32'h0);
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_ipc"},   instr_pc, 32'h0000_3000);
    chk({tag, "_fault"}, {31'h0, fault}, 32'h0);
    @(negedge clk);
    reset      = 1'b1;
    prev_valid = 1'b0;
  endtask

  // Called at a falling edge: compare, score deliveries, drive inputs, advance one cycle.
  task automatic do_row(input int i, input vec_t v);
    logic [31:0] p;
    logic [31:0] d;
    chk($sformatf("r%0d_req", i),   {31'h0, bus.imem_req}, {31'h0, v.e_req});
    chk($sformatf("r%0d_addr", i),  {20'h0, bus.imem_addr}, {20'h0, v.e_addr});
    chk($sformatf("r%0d_valid", i), {31'h0, instr_valid}, {31'h0, v.e_valid});
    chk($sformatf("r%0d_ipc", i),   instr_pc, v.e_ipc);
    chk($sformatf("r%0d_fault", i), {31'h0, fault}, {31'h0, v.e_fault});
    if (instr_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk($sformatf("r%0d_sb_unexpected", i), instr_pc, 32'hFFFF_FFFF);
      end else begin
        p = exp_q.pop_front();
        d = p - 32'h0000_3000;
        chk($sformatf("r%0d_sb_pc", i), instr_pc, p);
        chk($sformatf("r%0d_sb_instr", i), instr, mem_word(d[13:2]));
      end
    end
    prev_valid     = instr_valid;
    stall          = v.stall;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    bus.imem_ack   = v.ack;
    bus.imem_rdata = v.ack ? mem_word(bus.imem_addr) : 32'h0000_0000;
    if (v.ack && v.e_req) begin
      exp_q.push_back(32'h0000_3000 + {18'h0, v.e_addr, 2'b00});
    end
    @(negedge clk);
  endtask

  initial begin
    // Zero-wait sequential, 3-cycle latency with 4-cycle stall, delay-slot branch,
    // redirect with ack then in HOLD, and a later pending redirect overriding an earlier one.
    //              rb  req addr     v  ipc           f  st rv rpc           ack
    tbl.push_back(mk(0, 0, 12'h000, 0, 32'h3000, 0, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 12'h000, 0, 32'h3000, 0, 0, 0, 32'h0,    1));
    tbl.push_back(mk(0, 0, 12'h001, 1, 32'h3000, 0, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 12'h001, 0, 32'h3000, 0, 0, 0, 32'h0,    1));
    tbl.push_back(mk(0, 0, 12'h002, 1, 32'h3004, 0, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 12'h002, 0, 32'h3004, 0, 0, 0, 32'h0,    1));
    tbl.push_back(mk(0, 0, 12'h003, 1, 32'h3008, 0, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 12'h003, 0, 32'h3008, 0, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 12'h003, 0, 32'h3008, 0, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 12'h003, 0, 32'h3008, 0, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 12'h003, 0, 32'h3008, 0, 0, 0, 32'h0,    1));
    tbl.push_back(mk(0, 0, 12'h004, 1, 32'h300C, 0, 1, 0, 32'h0,    0));
    tbl.push_back(mk(0, 0, 12'h004, 1, 32'h300C, 0, 1, 0, 32'h0,    0));
    tbl.push_back(mk(0, 0, 12'h004, 1, 32'h300C, 0, 1, 0, 32'h0,    0));
    tbl.push_back(mk(0, 0, 12'h004, 1, 32'h300C, 0, 1, 0, 32'h0,    0));
    tbl.push_back(mk(0, 0, 12'h004, 1, 32'h300C, 0, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 12'h004, 0, 32'h300C, 0, 0, 0, 32'h0,    1));
    tbl.push_back(mk(0, 0, 12'h005, 1, 32'h3010, 0, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 12'h005, 0, 32'h3010, 0, 0, 1, 32'h3100, 0));
    tbl.push_back(mk(0, 1, 12'h005, 0, 32'h3010, 0, 0, 0, 32'h0,    1));
    tbl.push_back(mk(0, 0, 12'h040, 1, 32'h3014, 0, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 12'h040, 0, 32'h3014, 0, 0, 1, 32'h3180, 1));
    tbl.push_back(mk(0, 0, 12'h060, 1, 32'h3100, 0, 1, 1, 32'h3200, 0));
    tbl.push_back(mk(0, 0, 12'h080, 1, 32'h3100, 0, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 12'h080, 0, 32'h3100, 0, 0, 0, 32'h0,    1));
    tbl.push_back(mk(0, 0, 12'h081, 1, 32'h3200, 0, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 12'h081, 0, 32'h3200, 0, 0, 1, 32'h3300, 0));
    tbl.push_back(mk(0, 1, 12'h081, 0, 32'h3200, 0, 0, 1, 32'h3400, 0));
    tbl.push_back(mk(0, 1, 12'h081, 0, 32'h3200, 0, 0, 0, 32'h0,    1));
    tbl.push_back(mk(0, 0, 12'h100, 1, 32'h3204, 0, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 12'h100, 0, 32'h3204, 0, 0, 0, 32'h0,    1));
    tbl.push_back(mk(0, 0, 12'h101, 1, 32'h3400, 0, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 12'h101, 0, 32'h3400, 0, 0, 0, 32'h0,    0));
    part1_rows = tbl.size();
    // Out-of-range redirect coincident with ack: halt, buffer still consumed.
    tbl.push_back(mk(0, 0, 12'h000, 0, 32'h3000, 0, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 12'h000, 0, 32'h3000, 0, 0, 1, 32'h7000, 1));
    tbl.push_back(mk(0, 0, 12'h000, 1, 32'h3000, 1, 1, 0, 32'h0,    0));
    tbl.push_back(mk(0, 0, 12'h000, 1, 32'h3000, 1, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 0, 12'h000, 0, 32'h3000, 1, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 0, 12'h000, 0, 32'h3000, 1, 0, 0, 32'h0,    0));
    // Misaligned redirect while HOLD is stalled.
    tbl.push_back(mk(1, 0, 12'h000, 0, 32'h3000, 0, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 12'h000, 0, 32'h3000, 0, 0, 0, 32'h0,    1));
    tbl.push_back(mk(0, 0, 12'h001, 1, 32'h3000, 0, 1, 1, 32'h3102, 0));
    tbl.push_back(mk(0, 0, 12'h001, 1, 32'h3000, 1, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 0, 12'h001, 0, 32'h3000, 1, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 0, 12'h001, 0, 32'h3000, 1, 0, 0, 32'h0,    0));
    // Last legal word, then sequential step past the limit; a stray ack in HALT is ignored.
    tbl.push_back(mk(1, 0, 12'h000, 0, 32'h3000, 0, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 1, 12'h000, 0, 32'h3000, 0, 0, 0, 32'h0,    1));
    tbl.push_back(mk(0, 0, 12'h001, 1, 32'h3000, 0, 0, 1, 32'h6FFC, 0));
    tbl.push_back(mk(0, 1, 12'hFFF, 0, 32'h3000, 0, 0, 0, 32'h0,    1));
    tbl.push_back(mk(0, 0, 12'hFFF, 1, 32'h6FFC, 1, 0, 0, 32'h0,    0));
    tbl.push_back(mk(0, 0, 12'hFFF, 0, 32'h6FFC, 1, 0, 0, 32'h0,    1));
    tbl.push_back(mk(0, 0, 12'hFFF, 0, 32'h6FFC, 1, 0, 0, 32'h0,    0));

    reset = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    chk("rst_req",   {31'h0, bus.imem_req}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc",   instr_pc, 32'h0000_3000);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < part1_rows; i++) begin
      if (tbl[i].rst_before) reset_pulse($sformatf("r%0d_rst", i));
      do_row(i, tbl[i]);
    end

    // Reset while a request is outstanding: req must drop with no clock edge.
    chk("midreq_req_before", {31'h0, bus.imem_req}, 32'h1);
    reset_pulse("midreq");

    for (int i = part1_rows; i < tbl.size(); i++) begin
      if (tbl[i].rst_before) reset_pulse($sformatf("r%0d_rst", i));
      do_row(i, tbl[i]);
    end

    chk("sb_drain", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
